asg_keystream_ctrl: RTL and testbench

Sequencing and arbitration controller for the 4-bit alternating-step-generator keystream core. It validates and loads seeds, runs an optional warm-up that discards the first keystream steps, then shares the single core between two requesters. Arbitration is round-robin, and the block delivers one 4-bit keystream word per granted cycle. It sits between the seed/config source and the keystream consumers, and is the only block driving the core's load and step controls.

---
 rtl/asg_keystream_ctrl.sv | 147 ++++++++++++++
 tb/tb_asg_keystream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asg_keystream_ctrl.sv
// Seed loading, optional warm-up and round-robin sharing of the 4-bit ASG keystream core.
// Define ASG_WARMUP_EN to include the WARM state that discards WARMUP steps after each load.
module asg_keystream_ctrl #(
  parameter int unsigned WARMUP = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_seed_ctrl,
  input  logic [3:0] cfg_seed_0,
  input  logic [3:0] cfg_seed_1,
  output logic       cfg_err,
  output logic       asg_load,
  output logic [3:0] asg_seed_ctrl,
  output logic [3:0] asg_seed_0,
  output logic [3:0] asg_seed_1,
  output logic       asg_step,
  input  logic [3:0] asg_out,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       ks_valid,
  output logic [3:0] ks_data,
  output logic       ks_id,
  output logic       seeded,
  output logic       busy
);

  typedef enum logic [1:0] {UNSEEDED, LOAD, WARM, RUN} state_t;

  state_t state;
  logic   last_gnt;
`ifdef ASG_WARMUP_EN
  logic [7:0] warm_cnt;
`endif

  logic seeds_ok;
  logic any_req;
  logic pick;

  if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
    $error("asg_keystream_ctrl: WARMUP must be in 1..255");
  end

  assign seeds_ok = (|cfg_seed_ctrl) && (|cfg_seed_0) && (|cfg_seed_1);
  assign any_req  = |req;
  assign pick     = (req == 2'b11) ? ~last_gnt : req[1];

  assign cfg_ready = (state == UNSEEDED) || (state == RUN);
  assign seeded    = (state == RUN);
  assign busy      = (state == LOAD) || (state == WARM);
  // The core word only becomes valid the cycle after the step, so it is passed through under the registered valid.
  assign ks_data   = ks_valid ? asg_out : 4'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= UNSEEDED;
      last_gnt      <= 1'b1;
      asg_seed_ctrl <= 4'h0;
      asg_seed_0    <= 4'h0;
      asg_seed_1    <= 4'h0;
      asg_load      <= 1'b0;
      asg_step      <= 1'b0;
      gnt           <= 2'b00;
      cfg_err       <= 1'b0;
      ks_valid      <= 1'b0;
      ks_id         <= 1'b0;
`ifdef ASG_WARMUP_EN
      warm_cnt      <= 8'd0;
`endif
    end else begin
      asg_load <= 1'b0;
      asg_step <= 1'b0;
      gnt      <= 2'b00;
      cfg_err  <= 1'b0;
      ks_valid <= |gnt;
      ks_id    <= gnt[1];
      case (state)
        UNSEEDED: begin
          if (cfg_valid) begin
            if (seeds_ok) begin
              asg_seed_ctrl <= cfg_seed_ctrl;
              asg_seed_0    <= cfg_seed_0;
              asg_seed_1    <= cfg_seed_1;
              asg_load      <= 1'b1;
              state         <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
`ifdef ASG_WARMUP_EN
          state    <= WARM;
          warm_cnt <= 8'(WARMUP);
          asg_step <= 1'b1;
`else
          state <= RUN;
          if (any_req) begin
            gnt      <= pick ? 2'b10 : 2'b01;
            asg_step <= 1'b1;
            last_gnt <= pick;
          end
`endif
        end
        WARM: begin
`ifdef ASG_WARMUP_EN
          // The grant decided on the last warm edge lands in the first RUN cycle.
          if (warm_cnt == 8'd1) begin
            state <= RUN;
            if (any_req) begin
              gnt      <= pick ? 2'b10 : 2'b01;
              asg_step <= 1'b1;
              last_gnt <= pick;
            end
          end else begin
            warm_cnt <= warm_cnt - 8'd1;
            asg_step <= 1'b1;
          end
`else
          state <= UNSEEDED;
`endif
        end
        RUN: begin
          if (cfg_valid && seeds_ok) begin
            asg_seed_ctrl <= cfg_seed_ctrl;
            asg_seed_0    <= cfg_seed_0;
            asg_seed_1    <= cfg_seed_1;
            asg_load      <= 1'b1;
            state         <= LOAD;
          end else begin
            if (cfg_valid) begin
              cfg_err <= 1'b1;
            end
            if (any_req) begin
              gnt      <= pick ? 2'b10 : 2'b01;
              asg_step <= 1'b1;
              last_gnt <= pick;
            end
          end
        end
        default: state <= UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_asg_keystream_ctrl.sv
// Self-checking bench for asg_keystream_ctrl: drives a behavioural ASG core and scoreboards keystream words.
// Works with or without ASG_WARMUP_EN defined.
module tb_asg_keystream_ctrl;

  localparam int WARMUP = 8;
`ifdef ASG_WARMUP_EN
  localparam int W_STEPS = WARMUP;
`else
  localparam int W_STEPS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_seed_ctrl = 4'h0;
  logic [3:0] cfg_seed_0 = 4'h0;
  logic [3:0] cfg_seed_1 = 4'h0;
  logic       cfg_err;
  logic       asg_load;
  logic [3:0] asg_seed_ctrl;
  logic [3:0] asg_seed_0;
  logic [3:0] asg_seed_1;
  logic       asg_step;
  logic [3:0] asg_out;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       ks_valid;
  logic [3:0] ks_data;
  logic       ks_id;
  logic       seeded;
  logic       busy;

  always #5 clock = ~clock;

  asg_keystream_ctrl #(.WARMUP(WARMUP)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_seed_ctrl(cfg_seed_ctrl), .cfg_seed_0(cfg_seed_0), .cfg_seed_1(cfg_seed_1),
    .cfg_err(cfg_err), .asg_load(asg_load),
    .asg_seed_ctrl(asg_seed_ctrl), .asg_seed_0(asg_seed_0), .asg_seed_1(asg_seed_1),
    .asg_step(asg_step), .asg_out(asg_out),
    .req(req), .gnt(gnt),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_id(ks_id),
    .seeded(seeded), .busy(busy)
  );

  function automatic logic [3:0] lfsr4(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  // State packs {ctrl, lfsr0, lfsr1}; the control LFSR's msb picks which data LFSR advances.
  function automatic logic [11:0] asg_next(input logic [11:0] s);
    logic [3:0] c, r0, r1;
    c  = s[11:8];
    r0 = s[7:4];
    r1 = s[3:0];
    if (c[3]) r1 = lfsr4(r1);
    else      r0 = lfsr4(r0);
    c = lfsr4(c);
    return {c, r0, r1};
  endfunction

  function automatic logic [3:0] asg_word(input logic [11:0] s);
    return s[7:4] ^ s[3:0];
  endfunction

  logic [11:0] core_st = 12'h0;
  logic [3:0]  core_out = 4'h0;
  always @(posedge clock) begin
    if (asg_load) begin
      core_st <= {asg_seed_ctrl, asg_seed_0, asg_seed_1};
    end else if (asg_step) begin
      core_st  <= asg_next(core_st);
      core_out <= asg_word(asg_next(core_st));
    end
  end
  assign asg_out = core_out;

  typedef struct {
    int         due;
    logic       id;
    logic [3:0] data;
  } ks_item_t;

  ks_item_t    sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [11:0] ref_st = 12'h0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic cv,
                               input logic [3:0] sc, input logic [3:0] s0, input logic [3:0] s1);
    req           = r;
    cfg_valid     = cv;
    cfg_seed_ctrl = sc;
    cfg_seed_0    = s0;
    cfg_seed_1    = s1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Called before the edge on which the grant is decided; its word shows up two samples later.
  task automatic expectGrant(input logic id);
    ks_item_t it;
    ref_st  = asg_next(ref_st);
    it.due  = cyc + 2;
    it.id   = id;
    it.data = asg_word(ref_st);
    sb.push_back(it);
  endtask

  task automatic checkKs(input string tag);
    ks_item_t it;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      checkOutput({tag, ".ks_valid"}, 16'(ks_valid), 16'd1);
      checkOutput({tag, ".ks_id"}, 16'(ks_id), 16'(it.id));
      checkOutput({tag, ".ks_data"}, 16'(ks_data), 16'(it.data));
    end else begin
      checkOutput({tag, ".ks_idle"}, 16'(ks_valid), 16'd0);
    end
  endtask

  initial begin
    logic [1:0] exp_gnt;

    $display("[TB] start, warm-up steps = %0d", W_STEPS);
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("rst.gnt", 16'(gnt), 16'd0);
    checkOutput("rst.ks_valid", 16'(ks_valid), 16'd0);
    checkOutput("rst.ks_data", 16'(ks_data), 16'd0);
    checkOutput("rst.cfg_ready", 16'(cfg_ready), 16'd1);
    checkOutput("rst.seeded", 16'(seeded), 16'd0);
    checkOutput("rst.busy", 16'(busy), 16'd0);
    checkOutput("rst.load_step_err", 16'({asg_load, asg_step, cfg_err}), 16'd0);
    checkOutput("rst.seeds", 16'({asg_seed_ctrl, asg_seed_0, asg_seed_1}), 16'd0);
    reset = 1'b0;

    // Requests with no seed loaded must never be granted.
    applyStimulus(2'b11, 1'b0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("unseeded.gnt", 16'(gnt), 16'd0);
      checkOutput("unseeded.ks_valid", 16'(ks_valid), 16'd0);
      checkOutput("unseeded.cfg_ready", 16'(cfg_ready), 16'd1);
      checkOutput("unseeded.seeded", 16'(seeded), 16'd0);
    end

    // Zero seed rejected: a single cfg_err pulse, no load, seeds untouched.
    applyStimulus(2'b11, 1'b1, 4'h9, 4'h0, 4'hA);
    tick();
    checkOutput("badseed.cfg_err", 16'(cfg_err), 16'd1);
    checkOutput("badseed.asg_load", 16'(asg_load), 16'd0);
    checkOutput("badseed.seeds", 16'({asg_seed_ctrl, asg_seed_0, asg_seed_1}), 16'd0);
    checkOutput("badseed.cfg_ready", 16'(cfg_ready), 16'd1);
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    checkOutput("badseed.err_once", 16'(cfg_err), 16'd0);
    checkOutput("badseed.no_load", 16'(asg_load), 16'd0);
    checkOutput("badseed.seeded", 16'(seeded), 16'd0);

    // Valid load, then warm-up while an invalid cfg is offered and must be ignored.
    applyStimulus(2'b00, 1'b1, 4'h9, 4'h5, 4'hA);
    tick();
    checkOutput("load.asg_load", 16'(asg_load), 16'd1);
    checkOutput("load.asg_step", 16'(asg_step), 16'd0);
    checkOutput("load.busy", 16'(busy), 16'd1);
    checkOutput("load.cfg_ready", 16'(cfg_ready), 16'd0);
    checkOutput("load.seeds", 16'({asg_seed_ctrl, asg_seed_0, asg_seed_1}), 16'h95A);
    ref_st = {4'h9, 4'h5, 4'hA};
    for (int k = 0; k < W_STEPS; k++) ref_st = asg_next(ref_st);
    applyStimulus(2'b00, 1'b1, 4'h9, 4'h0, 4'hA);
    for (int k = 0; k < W_STEPS; k++) begin
      tick();
      checkOutput("warm.asg_step", 16'(asg_step), 16'd1);
      checkOutput("warm.busy", 16'(busy), 16'd1);
      checkOutput("warm.load_err", 16'({asg_load, cfg_err}), 16'd0);
      checkOutput("warm.seeded", 16'(seeded), 16'd0);
      checkKs("warm");
    end
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    checkOutput("run.seeded", 16'(seeded), 16'd1);
    checkOutput("run.busy", 16'(busy), 16'd0);
    checkOutput("run.asg_step", 16'(asg_step), 16'd0);
    checkOutput("run.cfg_err", 16'(cfg_err), 16'd0);

    // Both requesting: strict alternation starting at requester 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 1'b0, 4'h0, 4'h0, 4'h0);
      expectGrant(1'(i % 2));
      tick();
      exp_gnt = (i % 2 == 1) ? 2'b10 : 2'b01;
      checkOutput("rr.gnt", 16'(gnt), 16'(exp_gnt));
      checkOutput("rr.asg_step", 16'(asg_step), 16'd1);
      checkKs("rr");
    end
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    checkOutput("rr.gnt_off", 16'(gnt), 16'd0);
    checkKs("rr_tail");
    tick();
    checkKs("rr_drain");

    // Single requester held, then a valid cfg preempts the grant and re-runs warm-up.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b01, 1'b0, 4'h0, 4'h0, 4'h0);
      expectGrant(1'b0);
      tick();
      checkOutput("single.gnt", 16'(gnt), 16'd1);
      checkKs("single");
    end
    applyStimulus(2'b01, 1'b1, 4'h3, 4'h7, 4'hC);
    tick();
    checkOutput("reload.gnt", 16'(gnt), 16'd0);
    checkOutput("reload.asg_load", 16'(asg_load), 16'd1);
    checkOutput("reload.asg_step", 16'(asg_step), 16'd0);
    checkOutput("reload.busy", 16'(busy), 16'd1);
    checkOutput("reload.seeds", 16'({asg_seed_ctrl, asg_seed_0, asg_seed_1}), 16'h37C);
    checkKs("reload");
    ref_st = {4'h3, 4'h7, 4'hC};
    for (int k = 0; k < W_STEPS; k++) ref_st = asg_next(ref_st);
    applyStimulus(2'b01, 1'b0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < W_STEPS; k++) begin
      tick();
      checkOutput("rewarm.gnt", 16'(gnt), 16'd0);
      checkOutput("rewarm.asg_step", 16'(asg_step), 16'd1);
      checkKs("rewarm");
    end
    expectGrant(1'b0);
    tick();
    checkOutput("resume.gnt", 16'(gnt), 16'd1);
    checkOutput("resume.seeded", 16'(seeded), 16'd1);
    checkKs("resume");

    // Invalid cfg in RUN: error pulse, requester 1 still served.
    applyStimulus(2'b10, 1'b1, 4'h3, 4'h7, 4'h0);
    expectGrant(1'b1);
    tick();
    checkOutput("runerr.cfg_err", 16'(cfg_err), 16'd1);
    checkOutput("runerr.gnt", 16'(gnt), 16'd2);
    checkOutput("runerr.seeded", 16'(seeded), 16'd1);
    checkKs("runerr");
    applyStimulus(2'b10, 1'b0, 4'h0, 4'h0, 4'h0);
    expectGrant(1'b1);
    tick();
    checkOutput("runerr.err_once", 16'(cfg_err), 16'd0);
    checkOutput("runerr.gnt2", 16'(gnt), 16'd2);
    checkKs("runerr2");
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    checkKs("tail");
    tick();
    checkKs("drain");
    checkOutput("sb.empty", 16'(sb.size()), 16'd0);

    // Asynchronous reset in the middle of warm-up.
    applyStimulus(2'b00, 1'b1, 4'h1, 4'h2, 4'h3);
    tick();
    applyStimulus(2'b00, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst.asg_step", 16'(asg_step), 16'd0);
    checkOutput("arst.busy", 16'(busy), 16'd0);
    checkOutput("arst.seeded", 16'(seeded), 16'd0);
    checkOutput("arst.cfg_ready", 16'(cfg_ready), 16'd1);
    checkOutput("arst.seeds", 16'({asg_seed_ctrl, asg_seed_0, asg_seed_1}), 16'd0);
    checkOutput("arst.outs", 16'({asg_load, gnt, ks_valid, cfg_err}), 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("postrst.seeded", 16'(seeded), 16'd0);
    checkOutput("postrst.cfg_ready", 16'(cfg_ready), 16'd1);
    applyStimulus(2'b11, 1'b0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    checkOutput("postrst.gnt", 16'(gnt), 16'd0);
    checkOutput("postrst.asg_step", 16'(asg_step), 16'd0);
    checkOutput("postrst.ks_valid", 16'(ks_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
